// File: rtl/prach_ditfft3_ibf1.sv
// rtl/prach_ditfft3_ibf1.sv - inverse radix-3 stage-1 butterfly with triplet framing and fixed 3-cycle emission
module prach_ditfft3_ibf1 #(
  parameter int WIDTH = 18
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [WIDTH-1:0] din_dr,
  input  logic signed [WIDTH-1:0] din_di,
  input  logic                    din_dv,
  input  logic                    sync_in,
  output logic signed [WIDTH-1:0] dout_dr,
  output logic signed [WIDTH-1:0] dout_di,
  output logic                    dout_dv,
  output logic                    sync_out,
  output logic                    err_resync
);

  // Emission phase: which hold register is currently on the output.
  typedef enum logic [1:0] {
    EM_IDLE = 2'd0,
    EM_X0   = 2'd1,
    EM_X1   = 2'd2,
    EM_X2   = 2'd3
  } emit_t;

  emit_t                   emit_state;
  emit_t                   emit_next;
  logic [1:0]              idx_cnt;
  logic [1:0]              cur_idx;
  logic                    take0;
  logic                    take1;
  logic                    take2;
  logic                    resync;

  logic signed [WIDTH-1:0] col0_r, col0_i;
  logic signed [WIDTH-1:0] col1_r, col1_i;
  logic signed [WIDTH-1:0] x1_r, x1_i;
  logic signed [WIDTH-1:0] x2_r, x2_i;
  logic signed [WIDTH-1:0] hold0_r, hold0_i;
  logic signed [WIDTH-1:0] hold1_r, hold1_i;
  logic signed [WIDTH-1:0] hold2_r, hold2_i;

  // Index of the sample being presented; sync_in with a valid sample forces index 0.
  always_comb begin
    cur_idx = sync_in ? 2'd0 : idx_cnt;
    take0   = din_dv && (cur_idx == 2'd0);
    take1   = din_dv && (cur_idx == 2'd1);
    take2   = din_dv && (cur_idx == 2'd2);
    resync  = din_dv && sync_in && (idx_cnt != 2'd0);
  end

  // Input index counter: advances on valid samples only, wraps after index 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_cnt <= 2'd0;
    end else if (din_dv) begin
      idx_cnt <= take2 ? 2'd0 : cur_idx + 2'd1;
    end
  end

  // Resync pulse one cycle after a sync lands mid-triplet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_resync <= 1'b0;
    end else begin
      err_resync <= resync;
    end
  end

  // Collect registers for indices 0 and 1; data path only, no reset.
  always_ff @(posedge clk) begin
    if (take0) begin
      col0_r <= din_dr;
      col0_i <= din_di;
    end
    if (take1) begin
      col1_r <= din_dr;
      col1_i <= din_di;
    end
  end

  // Butterfly inverse at WIDTH+1 bits, floor-halved back to WIDTH bits.
  always_comb begin
    x1_r = WIDTH'(($signed({col1_r[WIDTH-1], col1_r}) - $signed({din_dr[WIDTH-1], din_dr})) >>> 1);
    x2_r = WIDTH'(($signed({col1_r[WIDTH-1], col1_r}) + $signed({din_dr[WIDTH-1], din_dr})) >>> 1);
    x1_i = WIDTH'(($signed({col1_i[WIDTH-1], col1_i}) - $signed({din_di[WIDTH-1], din_di})) >>> 1);
    x2_i = WIDTH'(($signed({col1_i[WIDTH-1], col1_i}) + $signed({din_di[WIDTH-1], din_di})) >>> 1);
  end

  // Hold registers loaded when a triplet completes; decoupled from collection so resyncs cannot disturb emission.
  always_ff @(posedge clk) begin
    if (take2) begin
      hold0_r <= col0_r;
      hold0_i <= col0_i;
      hold1_r <= x1_r;
      hold1_i <= x1_i;
      hold2_r <= x2_r;
      hold2_i <= x2_i;
    end
  end

  // Emission state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      emit_state <= EM_IDLE;
    end else begin
      emit_state <= emit_next;
    end
  end

  // Walk x0 -> x1 -> x2; a completed triplet always restarts at x0 (cannot arrive before x2 is shown).
  always_comb begin
    emit_next = emit_state;
    case (emit_state)
      EM_IDLE: emit_next = EM_IDLE;
      EM_X0:   emit_next = EM_X1;
      EM_X1:   emit_next = EM_X2;
      EM_X2:   emit_next = EM_IDLE;
    endcase
    if (take2) begin
      emit_next = EM_X0;
    end
  end

  // Output mux; everything is zero when no sample is being emitted.
  always_comb begin
    dout_dr  = '0;
    dout_di  = '0;
    dout_dv  = 1'b0;
    sync_out = 1'b0;
    case (emit_state)
      EM_IDLE: begin
        dout_dv = 1'b0;
      end
      EM_X0: begin
        dout_dr  = hold0_r;
        dout_di  = hold0_i;
        dout_dv  = 1'b1;
        sync_out = 1'b1;
      end
      EM_X1: begin
        dout_dr = hold1_r;
        dout_di = hold1_i;
        dout_dv = 1'b1;
      end
      EM_X2: begin
        dout_dr = hold2_r;
        dout_di = hold2_i;
        dout_dv = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_prach_ditfft3_ibf1.sv
// tb/tb_prach_ditfft3_ibf1.sv - self-checking bench for prach_ditfft3_ibf1 with a queue-based reference model
module tb_prach_ditfft3_ibf1;

  localparam int WIDTH = 18;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic signed [WIDTH-1:0] din_dr = '0;
  logic signed [WIDTH-1:0] din_di = '0;
  logic                    din_dv = 1'b0;
  logic                    sync_in = 1'b0;
  logic signed [WIDTH-1:0] dout_dr;
  logic signed [WIDTH-1:0] dout_di;
  logic                    dout_dv;
  logic                    sync_out;
  logic                    err_resync;

  prach_ditfft3_ibf1 #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din_dr     (din_dr),
    .din_di     (din_di),
    .din_dv     (din_dv),
    .sync_in    (sync_in),
    .dout_dr    (dout_dr),
    .dout_di    (dout_di),
    .dout_dv    (dout_dv),
    .sync_out   (sync_out),
    .err_resync (err_resync)
  );

  always #5 clk = ~clk;

  typedef struct {
    int dr;
    int di;
    int sy;
  } out_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   dv_seen = 0;
  int   err_seen = 0;
  int   m_idx = 0;
  int   m_c0r, m_c0i, m_c1r, m_c1i;
  out_t pend[$];

  task automatic chk(input string tag, input logic signed [31:0] obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int floor_half(input int v);
    if (v < 0 && (v % 2) != 0) return v / 2 - 1;
    return v / 2;
  endfunction

  function automatic int rnd_data();
    return int'($urandom_range(0, 262143)) - 131072;
  endfunction

  task automatic model_clear();
    m_idx = 0;
    pend.delete();
  endtask

  task automatic step(input bit dv, input bit sy, input int dr, input int di);
    int   idx;
    int   exp_err;
    out_t e;
    bit   have;
    din_dv  = dv;
    sync_in = sy;
    din_dr  = WIDTH'(dr);
    din_di  = WIDTH'(di);
    @(posedge clk);
    exp_err = (dv && sy && m_idx != 0) ? 1 : 0;
    if (dv) begin
      idx = sy ? 0 : m_idx;
      if (idx == 0) begin
        m_c0r = dr; m_c0i = di; m_idx = 1;
      end else if (idx == 1) begin
        m_c1r = dr; m_c1i = di; m_idx = 2;
      end else begin
        pend.push_back('{m_c0r, m_c0i, 1});
        pend.push_back('{floor_half(m_c1r - dr), floor_half(m_c1i - di), 0});
        pend.push_back('{floor_half(m_c1r + dr), floor_half(m_c1i + di), 0});
        m_idx = 0;
      end
    end
    have = pend.size() > 0;
    if (have) e = pend.pop_front();
    else e = '{0, 0, 0};
    #1;
    chk("dout_dv", 32'(dout_dv), have ? 1 : 0);
    chk("dout_dr", 32'(dout_dr), e.dr);
    chk("dout_di", 32'(dout_di), e.di);
    chk("sync_out", 32'(sync_out), e.sy);
    chk("err_resync", 32'(err_resync), exp_err);
    if (dout_dv === 1'b1) dv_seen++;
    if (err_resync === 1'b1) err_seen++;
  endtask

  task automatic expect_now(input string tag, input int dv, input int dr, input int di, input int sy);
    chk({tag, "_dv"}, 32'(dout_dv), dv);
    chk({tag, "_dr"}, 32'(dout_dr), dr);
    chk({tag, "_di"}, 32'(dout_di), di);
    chk({tag, "_sync"}, 32'(sync_out), sy);
  endtask

  task automatic floor_case(input string tag, input int y1, input int y2, input int x1, input int x2);
    step(1, 1, 7, 0);
    step(1, 0, y1, 0);
    step(1, 0, y2, 0);
    expect_now({tag, "_x0"}, 1, 7, 0, 1);
    step(0, 0, 0, 0);
    expect_now({tag, "_x1"}, 1, x1, 0, 0);
    step(0, 0, 0, 0);
    expect_now({tag, "_x2"}, 1, x2, 0, 0);
    step(0, 0, 0, 0);
  endtask

  initial begin
    // Reset state
    #2;
    expect_now("reset", 0, 0, 0, 0);
    chk("reset_err", 32'(err_resync), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_clear();
    step(0, 0, 0, 0);

    // Basic triplet
    step(1, 1, 100, 0);
    step(1, 0, 30, -4);
    step(1, 0, 50, 8);
    expect_now("basic_x0", 1, 100, 0, 1);
    step(0, 0, 0, 0);
    expect_now("basic_x1", 1, -10, -6, 0);
    step(0, 0, 0, 0);
    expect_now("basic_x2", 1, 40, 2, 0);
    step(0, 0, 0, 0);
    expect_now("basic_idle", 0, 0, 0, 0);

    // Floor arithmetic corners
    floor_case("floor_small", 3, 0, 1, 1);
    floor_case("floor_max", 131071, 131071, 0, 131071);
    floor_case("floor_min", -131072, -131072, 0, -131072);

    // Continuous stream of three triplets
    dv_seen = 0; err_seen = 0;
    for (int i = 0; i < 9; i++) step(1, (i % 3) == 0, rnd_data(), rnd_data());
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("stream_dv_count", 32'(dv_seen), 9);
    chk("stream_err_count", 32'(err_seen), 0);

    // Gapped input, garbage data during gaps
    dv_seen = 0;
    for (int i = 0; i < 6; i++) begin
      step(1, (i % 3) == 0, rnd_data(), rnd_data());
      step(0, ($urandom_range(0, 1) == 1), rnd_data(), rnd_data());
    end
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("gap_dv_count", 32'(dv_seen), 6);

    // Resync on the 2nd sample of a triplet
    err_seen = 0; dv_seen = 0;
    step(1, 1, 11, 12);
    step(1, 1, 21, 22);
    step(1, 0, 31, 32);
    step(1, 0, 41, 42);
    expect_now("resync_x0", 1, 21, 22, 1);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("resync_err_count", 32'(err_seen), 1);
    chk("resync_dv_count", 32'(dv_seen), 3);

    // Resync arriving while a triplet is being emitted
    step(1, 1, rnd_data(), rnd_data());
    step(1, 0, rnd_data(), rnd_data());
    step(1, 0, rnd_data(), rnd_data());
    step(1, 1, rnd_data(), rnd_data());
    step(1, 1, rnd_data(), rnd_data());
    step(1, 0, rnd_data(), rnd_data());
    step(1, 0, rnd_data(), rnd_data());
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);

    // Reset in the cycle after sync_out
    step(1, 1, 500, -500);
    step(1, 0, 60, 70);
    step(1, 0, 80, 90);
    step(0, 0, 0, 0);
    rst_n = 1'b0;
    model_clear();
    #1;
    expect_now("rst_mid", 0, 0, 0, 0);
    @(posedge clk); #1;
    expect_now("rst_hold", 0, 0, 0, 0);
    rst_n = 1'b1;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 0, 1000, 2000);
    step(1, 0, 10, 20);
    step(1, 0, 30, 40);
    expect_now("post_rst_x0", 1, 1000, 2000, 1);
    step(0, 0, 0, 0);
    expect_now("post_rst_x1", 1, -10, -10, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 6) == 0, rnd_data(), rnd_data());
    end
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
